vmem_arbiter: RTL and testbench

VMEM_ARBITER -- requirements
Module: vmem_arbiter

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vmem_fill_cnt.sv | 61 ++++++
 rtl/vmem_arbiter.sv | 139 +++++++++++++
 tb/tb_vmem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA framebuffer arbiter slice.
// Holds the default screen geometry, pixel/address widths, the fill FSM state
// type and a helper that packs a {column,row} pair into a framebuffer address.
// No ports (package).
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int DATA_W   = 24;
  localparam int ADDR_W   = 19;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fillState_e;

  // Framebuffer addresses are the column in the upper bits, row in the lower.
  function automatic logic [18:0] packAddr(input logic [9:0] h, input logic [8:0] v);
    return {h, v};
  endfunction

endpackage

// File: rtl/vmem_fill_cnt.sv
// Fill address generator for the full-screen clear.
// Walks fh across a line, then steps fv, and flags the final visible pixel.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   clear_i       - restart the walk at (0,0)
//   advance_i     - the current pixel was written this cycle, step to the next
//   fh_o, fv_o    - current fill column / row
//   last_o        - current pixel is (H_ACTIVE-1, V_ACTIVE-1)
module vmem_fill_cnt #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       advance_i,
  output logic [9:0] fh_o,
  output logic [8:0] fv_o,
  output logic       last_o
);

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [8:0] V_LAST = 9'(V_ACTIVE - 1);

  logic [9:0] fh_q, fh_d;
  logic [8:0] fv_q, fv_d;

  assign fh_o   = fh_q;
  assign fv_o   = fv_q;
  assign last_o = (fh_q == H_LAST) && (fv_q == V_LAST);

  // Counters only move when a fill write actually happened, so a stalled
  // cycle (VGA owning the port) leaves the position untouched. Stepping past
  // the last pixel wraps to (0,0); the FSM has left FILL by then.
  always_comb begin
    fh_d = fh_q;
    fv_d = fv_q;
    if (clear_i) begin
      fh_d = '0;
      fv_d = '0;
    end else if (advance_i) begin
      if (fh_q == H_LAST) begin
        fh_d = '0;
        fv_d = (fv_q == V_LAST) ? '0 : fv_q + 9'd1;
      end else begin
        fh_d = fh_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fh_q <= '0;
      fv_q <= '0;
    end else begin
      fh_q <= fh_d;
      fv_q <= fv_d;
    end
  end

endmodule

// File: rtl/vmem_arbiter.sv
// Single-port framebuffer arbiter shared by the VGA scan-out, a full-screen
// fill engine and a pixel writer. Fixed priority VGA > fill > writer, with at
// most one framebuffer access per cycle.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   vga_req, h_addr, v_addr     - scan-out read request and pixel position
//   vga_data                    - read pixel, one cycle after the request
//   wr_valid, wr_ready          - writer handshake
//   wr_h, wr_v, wr_data         - writer pixel position and colour
//   clr_start, clr_color        - start a fill with the given colour
//   clr_busy, clr_done          - fill in progress / final pixel written
//   mem_en, mem_we, mem_addr    - framebuffer control and {h,v} address
//   mem_wdata, mem_rdata        - framebuffer write / read data
module vmem_arbiter
  import vga_pkg::fillState_e;
  import vga_pkg::IDLE;
  import vga_pkg::FILL;
  import vga_pkg::packAddr;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int DATA_W   = vga_pkg::DATA_W,
  parameter int ADDR_W   = vga_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [9:0]        h_addr,
  input  logic [8:0]        v_addr,
  output logic [DATA_W-1:0] vga_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [9:0]        wr_h,
  input  logic [8:0]        wr_v,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  fillState_e        state_q, state_d;
  logic [DATA_W-1:0] fillColor_q, fillColor_d;
  logic              vgaPend_q;
  logic              done_q, done_d;

  logic              vgaGrant;
  logic              fillGrant;
  logic              wrGrant;
  logic              fillStart;
  logic [9:0]        fillH;
  logic [8:0]        fillV;
  logic              fillLast;

  // Every grant is masked by rst so nothing touches memory during reset.
  // VGA is never delayed; fill takes any cycle VGA leaves free; the writer
  // only gets idle cycles where no fill is being requested either.
  assign vgaGrant  = vga_req && !rst;
  assign fillGrant = (state_q == FILL) && !vga_req && !rst;
  assign wr_ready  = !vga_req && (state_q == IDLE) && !clr_start && !rst;
  assign wrGrant   = wr_valid && wr_ready;
  assign fillStart = (state_q == IDLE) && clr_start && !rst;

  vmem_fill_cnt #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE)
  ) u_fill_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (fillStart),
    .advance_i(fillGrant),
    .fh_o     (fillH),
    .fv_o     (fillV),
    .last_o   (fillLast)
  );

  // Fill FSM: a start in IDLE latches the colour; writing the last pixel
  // returns to IDLE and raises done for one cycle. Starts in FILL are ignored.
  always_comb begin
    state_d     = state_q;
    fillColor_d = fillColor_q;
    done_d      = 1'b0;
    if (fillStart) begin
      state_d     = FILL;
      fillColor_d = clr_color;
    end else if (fillGrant && fillLast) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fillColor_q <= '0;
      vgaPend_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fillColor_q <= fillColor_d;
      vgaPend_q   <= vgaGrant;
      done_q      <= done_d;
    end
  end

  // Port mux: address/data are zeroed when their access is not granted.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (vgaGrant) begin
      mem_en   = 1'b1;
      mem_addr = ADDR_W'(packAddr(h_addr, v_addr));
    end else if (fillGrant) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ADDR_W'(packAddr(fillH, fillV));
      mem_wdata = fillColor_q;
    end else if (wrGrant) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ADDR_W'(packAddr(wr_h, wr_v));
      mem_wdata = wr_data;
    end
  end

  // Status outputs are also masked by rst, which covers the first reset
  // cycle before the registers have been cleared.
  assign vga_data = (vgaPend_q && !rst) ? mem_rdata : '0;
  assign clr_busy = (state_q == FILL) && !rst;
  assign clr_done = done_q && !rst;

endmodule

// File: tb/tb_vmem_arbiter.sv
// Randomized scoreboard bench for vmem_arbiter on a small 12x6 screen.
// A behavioural model (remaining-pixel count, reference image) predicts each
// cycle's handshake/status outputs plus the ordered list of framebuffer reads
// and writes; a monitor pops and compares them as the DUT presents them.
module tb_vmem_arbiter;

  localparam int H    = 12;
  localparam int V    = 6;
  localparam int DW   = 24;
  localparam int AW   = 19;
  localparam int NCYC = 4000;

  typedef struct packed {
    logic          ready;
    logic          busy;
    logic          done;
    logic [DW-1:0] vgaData;
  } cycExp_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wrExp_t;

  logic          clk;
  logic          rst;
  logic          vga_req;
  logic [9:0]    h_addr;
  logic [8:0]    v_addr;
  logic [DW-1:0] vga_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [9:0]    wr_h;
  logic [8:0]    wr_v;
  logic [DW-1:0] wr_data;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          clr_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  cycExp_t       cycQ[$];
  wrExp_t        wrQ[$];
  logic [AW-1:0] rdQ[$];

  logic [DW-1:0] fbMem  [int];
  logic [DW-1:0] refImg [int];

  // Reference model state
  bit            fillActive = 0;
  int            fillIdx    = 0;
  logic [DW-1:0] fillColor  = '0;
  bit            doneFlag   = 0;
  bit            prevRead   = 0;
  logic [DW-1:0] prevData   = '0;
  bit            wrActive   = 0;
  bit            midRstDone = 0;

  cycExp_t monE;
  wrExp_t  monW;
  logic [AW-1:0] monA;

  vmem_arbiter #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .DATA_W  (DW),
    .ADDR_W  (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vga_req  (vga_req),
    .h_addr   (h_addr),
    .v_addr   (v_addr),
    .vga_data (vga_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_h     (wr_h),
    .wr_v     (wr_v),
    .wr_data  (wr_data),
    .clr_start(clr_start),
    .clr_color(clr_color),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Framebuffer model: synchronous single-port RAM, read data one cycle later.
  always @(posedge clk) begin
    if (mem_en && mem_we) fbMem[int'(mem_addr)] = mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= fbMem.exists(int'(mem_addr)) ? fbMem[int'(mem_addr)] : '0;
  end

  function automatic logic [DW-1:0] refGet(input int a);
    return refImg.exists(a) ? refImg[a] : '0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of random inputs and advance the reference model.
  task automatic applyStimulus(input int cyc);
    int            vgaProb;
    bit            wasActive;
    cycExp_t       e;
    logic [AW-1:0] a;
    case (cyc / 700)
      0:       vgaProb = 0;
      1:       vgaProb = 50;
      2:       vgaProb = 90;
      3:       vgaProb = 30;
      default: vgaProb = 60;
    endcase

    rst = (cyc < 3) || ($urandom_range(0, 499) == 0);
    if (cyc >= 2100 && !midRstDone && fillActive && fillIdx == H + 4) begin
      rst        = 1'b1;
      midRstDone = 1'b1;
    end

    vga_req = ($urandom_range(0, 99) < vgaProb);
    h_addr  = 10'($urandom_range(0, H));
    v_addr  = 9'($urandom_range(0, V));

    clr_start = (cyc == 5) || (cyc == 705) || ($urandom_range(0, 79) == 0);
    clr_color = DW'($urandom);

    if (!wrActive && $urandom_range(0, 2) == 0) begin
      wrActive = 1'b1;
      wr_h     = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, H + 1));
      wr_v     = ($urandom_range(0, 7) == 0) ? 9'h1FF  : 9'($urandom_range(0, V + 1));
      wr_data  = DW'($urandom);
    end
    wr_valid = wrActive;

    e.vgaData = (!rst && prevRead) ? prevData : '0;
    if (rst) begin
      e.ready    = 1'b0;
      e.busy     = 1'b0;
      e.done     = 1'b0;
      fillActive = 0;
      doneFlag   = 0;
      prevRead   = 0;
    end else begin
      wasActive = fillActive;
      e.done    = doneFlag;
      doneFlag  = 0;
      e.busy    = wasActive;
      e.ready   = !vga_req && !wasActive && !clr_start;
      prevRead  = vga_req;
      if (vga_req) begin
        a = {h_addr, v_addr};
        rdQ.push_back(a);
        prevData = refGet(int'(a));
      end else if (wasActive) begin
        a = {10'(fillIdx % H), 9'(fillIdx / H)};
        wrQ.push_back({a, fillColor});
        refImg[int'(a)] = fillColor;
        fillIdx++;
        if (fillIdx == H * V) begin
          fillActive = 0;
          doneFlag   = 1;
        end
      end else if (wr_valid && e.ready) begin
        a = {wr_h, wr_v};
        wrQ.push_back({a, wr_data});
        refImg[int'(a)] = wr_data;
        wrActive = 0;
      end
      if (!wasActive && clr_start) begin
        fillActive = 1;
        fillIdx    = 0;
        fillColor  = clr_color;
      end
    end
    cycQ.push_back(e);
  endtask

  // Monitor: compares status every modelled cycle and pops the access queues
  // whenever the DUT actually drives a framebuffer read or write.
  always @(negedge clk) begin
    if (cycQ.size() > 0) begin
      monE = cycQ.pop_front();
      checkOutput("wr_ready", 32'(wr_ready), 32'(monE.ready));
      checkOutput("clr_busy", 32'(clr_busy), 32'(monE.busy));
      checkOutput("clr_done", 32'(clr_done), 32'(monE.done));
      checkOutput("vga_data", 32'(vga_data), 32'(monE.vgaData));
      if (mem_en && mem_we) begin
        checkOutput("write_during_vga", 32'(vga_req), 32'd0);
        if (wrQ.size() == 0) begin
          checkOutput("unexpected_write", 32'(mem_addr), 32'h7FFFFFFF);
        end else begin
          monW = wrQ.pop_front();
          checkOutput("wr_addr", 32'(mem_addr), 32'(monW.addr));
          checkOutput("wr_data", 32'(mem_wdata), 32'(monW.data));
        end
      end else if (mem_en) begin
        if (rdQ.size() == 0) begin
          checkOutput("unexpected_read", 32'(mem_addr), 32'h7FFFFFFF);
        end else begin
          monA = rdQ.pop_front();
          checkOutput("rd_addr", 32'(mem_addr), 32'(monA));
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    vga_req   = 1'b0;
    h_addr    = '0;
    v_addr    = '0;
    wr_valid  = 1'b0;
    wr_h      = '0;
    wr_v      = '0;
    wr_data   = '0;
    clr_start = 1'b0;
    clr_color = '0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      applyStimulus(cyc);
    end
    @(negedge clk);
    #1;
    checkOutput("writes_left", 32'(wrQ.size()), 32'd0);
    checkOutput("reads_left", 32'(rdQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
